// File: rtl/uart_tx_time_report_pkg.sv
// uart_tx_time_report_pkg: shared UART link constants and report FSM encoding
package uart_tx_time_report_pkg;
  localparam int MSG_LEN = 13;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_R     = 8'h72;
  localparam logic [7:0] ASCII_S     = 8'h73;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;
  typedef enum logic {IDLE = ST_IDLE, SEND = ST_SEND} state_t;
endpackage

// File: rtl/uart_tx_time_report_bin2ascii2.sv
// uart_tx_time_report_bin2ascii2: 7-bit value clamped to 99, split into two ASCII digits
module uart_tx_time_report_bin2ascii2
  import uart_tx_time_report_pkg::*;
(
  input  logic [6:0] val,
  output logic [7:0] tens,
  output logic [7:0] ones
);
  logic [6:0] v;
  // clamp then split into decimal digits
  always_comb begin
    v = val > 7'd99 ? 7'd99 : val;
    tens = ASCII_0 + 8'(v / 7'd10);
    ones = ASCII_0 + 8'(v % 7'd10);
  end
endmodule

// File: rtl/uart_tx_time_report.sv
// uart_tx_time_report: snapshots the stopwatch time and pushes "HH:MM:SS.CC\r\n" into the TX FIFO
module uart_tx_time_report
  import uart_tx_time_report_pkg::*;
#(
  parameter int MSG_LEN = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_send,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [6:0] i_msec,
  input  logic       i_tx_full,
  output logic       o_tx_push,
  output logic [7:0] o_tx_data,
  output logic       o_busy
);
  state_t     state;
  logic [4:0] hour_q;
  logic [5:0] min_q, sec_q;
  logic [6:0] msec_q;
  logic [3:0] idx;
  logic [7:0] h_t, h_o, m_t, m_o, s_t, s_o, c_t, c_o, sel;
  uart_tx_time_report_bin2ascii2 u_hour (.val({2'b00, hour_q}), .tens(h_t), .ones(h_o));
  uart_tx_time_report_bin2ascii2 u_min  (.val({1'b0, min_q}),   .tens(m_t), .ones(m_o));
  uart_tx_time_report_bin2ascii2 u_sec  (.val({1'b0, sec_q}),   .tens(s_t), .ones(s_o));
  uart_tx_time_report_bin2ascii2 u_msec (.val(msec_q),          .tens(c_t), .ones(c_o));
  assign o_busy    = state == SEND;
  assign o_tx_push = o_busy && !i_tx_full;
  // byte of the report line at the current index; zero while idle
  always_comb begin
    case (idx)
      4'd0:    sel = h_t;
      4'd1:    sel = h_o;
      4'd2:    sel = ASCII_COLON;
      4'd3:    sel = m_t;
      4'd4:    sel = m_o;
      4'd5:    sel = ASCII_COLON;
      4'd6:    sel = s_t;
      4'd7:    sel = s_o;
      4'd8:    sel = ASCII_DOT;
      4'd9:    sel = c_t;
      4'd10:   sel = c_o;
      4'd11:   sel = ASCII_CR;
      4'd12:   sel = ASCII_LF;
      default: sel = 8'h00;
    endcase
    o_tx_data = o_busy ? sel : 8'h00;
  end
  // report FSM: capture snapshot on request, advance index only on accepted pushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      hour_q <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      msec_q <= '0;
    end else if (state == IDLE) begin
      if (i_send) begin
        state  <= SEND;
        idx    <= '0;
        hour_q <= i_hour;
        min_q  <= i_min;
        sec_q  <= i_sec;
        msec_q <= i_msec;
      end
    end else if (o_tx_push) begin
      idx   <= idx == 4'(MSG_LEN - 1) ? '0 : idx + 4'd1;
      state <= idx == 4'(MSG_LEN - 1) ? IDLE : SEND;
    end
  end
endmodule

// File: tb/tb_uart_tx_time_report.sv
// tb_uart_tx_time_report: randomized self-checking bench against a line-format reference model
module tb_uart_tx_time_report;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_send = 1'b0;
  logic [4:0] i_hour = '0;
  logic [5:0] i_min = '0;
  logic [5:0] i_sec = '0;
  logic [6:0] i_msec = '0;
  logic       i_tx_full = 1'b0;
  logic       o_tx_push;
  logic [7:0] o_tx_data;
  logic       o_busy;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] cap[$];

  uart_tx_time_report dut (
    .clk(clk), .rst(rst), .i_send(i_send), .i_hour(i_hour), .i_min(i_min),
    .i_sec(i_sec), .i_msec(i_msec), .i_tx_full(i_tx_full),
    .o_tx_push(o_tx_push), .o_tx_data(o_tx_data), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // record every byte the FIFO would accept
  always @(negedge clk) if (o_tx_push) cap.push_back(o_tx_data);

  // expected byte k of the line "HH:MM:SS.CC\r\n" for the given time
  function automatic logic [7:0] ref_byte(int h, int m, int s, int c, int k);
    int f[4];
    int v;
    f = '{h, m, s, c};
    case (k)
      2, 5:    return 8'h3A;
      8:       return 8'h2E;
      11:      return 8'h0D;
      12:      return 8'h0A;
      default: begin
        v = f[k / 3];
        v = v > 99 ? 99 : v;
        return 8'(k % 3 == 0 ? 48 + v / 10 : 48 + v % 10);
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(int h, int m, int s, int c);
    i_hour = 5'(h); i_min = 6'(m); i_sec = 6'(s); i_msec = 7'(c);
    i_send = 1'b1;
    step();
    i_send = 1'b0;
  endtask

  task automatic test_reset();
    i_send = 1'b1;
    repeat (3) step();
    vectors++;
    if ({o_busy, o_tx_push, o_tx_data} !== 10'h000) begin
      miscompares++;
      $display("FAIL reset: busy/push/data=%b/%b/%h required 0/0/00", o_busy, o_tx_push, o_tx_data);
    end
    i_send = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_message(int h, int m, int s, int c);
    logic [9:0] exp;
    start(h, m, s, c);
    for (int k = 0; k < 13; k++) begin
      exp = {2'b11, ref_byte(h, m, s, c, k)};
      vectors++;
      if ({o_busy, o_tx_push, o_tx_data} !== exp) begin
        miscompares++;
        $display("FAIL msg %0d:%0d:%0d.%0d idx %0d: busy/push/data=%b/%b/%h required %b/%b/%h",
                 h, m, s, c, k, o_busy, o_tx_push, o_tx_data, exp[9], exp[8], exp[7:0]);
      end
      step();
    end
    vectors++;
    if ({o_busy, o_tx_push, o_tx_data} !== 10'h000) begin
      miscompares++;
      $display("FAIL msg_end: busy/push/data=%b/%b/%h required 0/0/00", o_busy, o_tx_push, o_tx_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      test_message($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 127));
  endtask

  task automatic test_stall();
    int k = 0;
    int cyc = 0;
    logic [9:0] exp;
    start(12, 34, 56, 78);
    while (k < 13 && cyc < 40) begin
      cyc++;
      i_tx_full = cyc >= 5 && cyc <= 9;
      #1;
      exp = {1'b1, !i_tx_full, ref_byte(12, 34, 56, 78, k)};
      vectors++;
      if ({o_busy, o_tx_push, o_tx_data} !== exp) begin
        miscompares++;
        $display("FAIL stall cycle %0d idx %0d: busy/push/data=%b/%b/%h required %b/%b/%h",
                 cyc, k, o_busy, o_tx_push, o_tx_data, exp[9], exp[8], exp[7:0]);
      end
      if (!i_tx_full) k++;
      step();
    end
    i_tx_full = 1'b0;
    #1;
    vectors++;
    if (cyc != 18 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_len: busy cycles=%0d busy_after=%b required 18/0", cyc, o_busy);
    end
  endtask

  task automatic test_ignore_send();
    logic [9:0] exp;
    start(12, 34, 56, 78);
    for (int k = 0; k < 13; k++) begin
      if (k == 6) begin
        i_send = 1'b1;
        i_hour = 5'd7; i_min = 6'd8; i_sec = 6'd9; i_msec = 7'd10;
      end
      #1;
      exp = {2'b11, ref_byte(12, 34, 56, 78, k)};
      vectors++;
      if ({o_busy, o_tx_push, o_tx_data} !== exp) begin
        miscompares++;
        $display("FAIL ignore idx %0d: busy/push/data=%b/%b/%h required %b/%b/%h",
                 k, o_busy, o_tx_push, o_tx_data, exp[9], exp[8], exp[7:0]);
      end
      step();
    end
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_gap: busy=%b required 0", o_busy);
    end
    step();
    i_send = 1'b0;
    for (int k = 0; k < 13; k++) begin
      exp = {2'b11, ref_byte(7, 8, 9, 10, k)};
      vectors++;
      if ({o_busy, o_tx_push, o_tx_data} !== exp) begin
        miscompares++;
        $display("FAIL next_msg idx %0d: busy/push/data=%b/%b/%h required %b/%b/%h",
                 k, o_busy, o_tx_push, o_tx_data, exp[9], exp[8], exp[7:0]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    cap.delete();
    start(12, 34, 56, 78);
    repeat (7) step();
    vectors++;
    if (o_tx_data !== ref_byte(12, 34, 56, 78, 7)) begin
      miscompares++;
      $display("FAIL rst_mid_pre: data=%h required %h", o_tx_data, ref_byte(12, 34, 56, 78, 7));
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({o_busy, o_tx_push, o_tx_data} !== 10'h000) begin
      miscompares++;
      $display("FAIL rst_mid: busy/push/data=%b/%b/%h required 0/0/00", o_busy, o_tx_push, o_tx_data);
    end
    repeat (3) step();
    rst = 1'b0;
    step();
    vectors++;
    if (cap.size() != 7 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_pushes: pushes=%0d busy=%b required 7/0", cap.size(), o_busy);
    end
    test_message($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 99));
  endtask

  initial begin
    test_reset();
    test_message(12, 34, 56, 78);
    test_message(0, 0, 0, 0);
    test_message(31, 59, 59, 120);
    test_random();
    test_stall();
    test_ignore_send();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
